data_mem_responder: RTL
=======================

# data_mem_responder

Data-memory responder for the SCC single-cycle computer: the slave end of the SCC data bus (`data_addr`, `data_out`, `data_read`, `data_write`). It services word reads and writes to an internal RAM with a configurable number of wait states. It returns read data with a one-cycle `data_ready` pulse and flags protocol and addressing errors. An optional memory-mapped I/O page exposes a free-running cycle counter and an output port.

## Interface
- `DEPTH_WORDS`, 1024: RAM depth in 32-bit words; power of two.
- `WAIT_CYCLES`, 0: extra wait states between request acceptance and `data_ready`; 0–15.
- `clk`  input  1  system clock; all state updates on rising edge.
- `reset`  input  1  synchronous, active-high reset.
- `data_addr`  input  32  byte address from SCC.
- `data_wdata`  input  32  write data (connects to SCC `data_out`).
- `data_read`  input  1  read request, held until `data_ready`.
- `data_write`  input  1  write request, held until `data_ready`.
- `data_rdata`  output  32  read response data, registered.
- `data_ready`  output  1  one-cycle response pulse.
- `data_err`  output  1  sticky error flag.
- `out_port`  output  32  MMIO output register.

## Operation
- FSM states: IDLE, WAIT, RESP.
- IDLE: if `data_read | data_write`, the request is accepted at that edge.
  - WAIT_CYCLES=0: go to RESP.
  - Otherwise: load wait counter with WAIT_CYCLES−1 and go to WAIT.
- WAIT: decrement the counter; go to RESP when it is 0. Inputs are ignored.
- RESP: `data_ready`=1 for exactly this cycle. Next edge returns to IDLE without sampling inputs. The requester must drop or change its request after seeing `data_ready`.
- Address decode at acceptance. Word index = `data_addr[log2(DEPTH_WORDS)+1:2]`.
  - RAM hit: `data_addr` < 4·DEPTH_WORDS and `data_addr[1:0]`==0.
- Write: RAM word (or MMIO register) updated at the acceptance edge.
- Read: data captured into `data_rdata` at the acceptance edge. `data_rdata` holds until the next accepted read.
- Errors: set `data_err`=1 (sticky until reset); the access still completes with `data_ready` and normal latency. Cases:
  - Misaligned address (`data_addr[1:0]`≠0): write dropped; read returns 0.
  - Unmapped address: write dropped; read returns 0.
  - `data_read` and `data_write` both high: no memory change; `data_rdata` loaded with 0.
- MMIO page, when compiled in:
  - 0xFFFF_FF00: cycle counter. Read-only; writes are ignored and set `data_err`.
  - 0xFFFF_FF04: `out_port`. Read/write.
- Cycle counter: 32-bit, cleared by reset, +1 every non-reset cycle, wraps 0xFFFF_FFFF→0. A read returns the counter value before the acceptance edge's increment.
- RAM contents are not cleared by reset; simulation initial contents are 0.

## Timing
- Reset values: `data_rdata`=0, `data_ready`=0, `data_err`=0, `out_port`=0, counter=0, FSM=IDLE.
- Latency: request accepted at edge N, so `data_ready` is high in the cycle after edge N+WAIT_CYCLES.
- Throughput: one access per WAIT_CYCLES+2 cycles maximum.
- Reset during WAIT or RESP:
  - Aborts the access; next cycle is IDLE with `data_ready`=0.
  - A write committed at acceptance is not rolled back.
- Request deasserted during WAIT: the response still completes.
- `out_port` changes in the cycle after the acceptance edge of its write.

## Configuration
- `DMEM_MMIO_EN` defined: MMIO page decoded as above; counter and `out_port` register present.
- `DMEM_MMIO_EN` undefined:
  - The MMIO addresses are unmapped (error behaviour above).
  - Counter logic is absent; `out_port` is tied to 0.

## Test plan
- Reset, WAIT_CYCLES=0: write 0xDEAD_BEEF to 0x10, then read 0x10. Each `data_ready` pulses 1 cycle after acceptance; read gives `data_rdata`=0xDEAD_BEEF; `data_err`=0.
- WAIT_CYCLES=3: read 0x10 accepted at edge N. `data_ready` high only in the cycle after edge N+3; inputs toggled during WAIT have no effect.
- Error cases:
  - Read 0x12 (misaligned): `data_rdata`=0, `data_err`=1.
  - Write 0x1000 with DEPTH_WORDS=1024: dropped, `data_err` stays 1.
  - Read and write high together: no RAM change.
  - Reset clears `data_err`.
- With `DMEM_MMIO_EN`:
  - Write 0x0000_00A5 to 0xFFFF_FF04: `out_port`=0xA5 next cycle.
  - Two counter reads accepted 10 cycles apart: values differ by exactly 10.
  - Force counter to 0xFFFF_FFFF: next value is 0.
- Without `DMEM_MMIO_EN`: read 0xFFFF_FF00 returns 0 with `data_err`=1; `out_port` stays 0 after writing 0xFFFF_FF04.
- Assert reset in WAIT after write 0x5 to 0x20 (WAIT_CYCLES=2): no `data_ready`, FSM IDLE; a later read of 0x20 returns 0x5.

Source files
------------

// File: rtl/data_mem_responder.sv
// ============================================================================
// data_mem_responder: SCC data-bus slave with wait-stated RAM, sticky error
// flag and optional MMIO page (cycle counter + out_port) under DMEM_MMIO_EN.
// Revision: 1.0
// ============================================================================
`default_nettype none

module data_mem_responder #(
  parameter int DEPTH_WORDS = 1024,
  parameter int WAIT_CYCLES = 0
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] data_addr,
  input  logic [31:0] data_wdata,
  input  logic        data_read,
  input  logic        data_write,
  output logic [31:0] data_rdata,
  output logic        data_ready,
  output logic        data_err,
  output logic [31:0] out_port
);

  localparam int AW = $clog2(DEPTH_WORDS);
  localparam logic [3:0] WAIT_LOAD = (WAIT_CYCLES == 0) ? 4'd0 : 4'(WAIT_CYCLES - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_RESP = 2'd2
  } state_t;

  state_t      state, state_nxt;
  logic [3:0]  wait_cnt, wait_cnt_nxt;

  logic [31:0] mem [DEPTH_WORDS];

  logic          accept;
  logic          both;
  logic          aligned;
  logic          in_range;
  logic          ram_hit;
  logic          cnt_hit;
  logic          out_hit;
  logic          req_err;
  logic          ram_write;
  logic [AW-1:0] word_idx;
  logic [31:0]   mmio_rdata;
  logic [31:0]   rd_val;

  assign accept    = (state == S_IDLE) && (data_read || data_write);
  assign both      = data_read & data_write;
  assign aligned   = (data_addr[1:0] == 2'b00);
  assign in_range  = (data_addr[31:AW+2] == '0);
  assign ram_hit   = in_range & aligned;
  assign word_idx  = data_addr[AW+1:2];
  assign ram_write = accept & data_write & ~data_read & ram_hit;
  // Writes to the read-only counter are flagged like any other bad access.
  assign req_err   = both | ~(ram_hit | cnt_hit | out_hit) | (data_write & cnt_hit);

`ifdef DMEM_MMIO_EN
  logic [31:0] cycle_cnt;
  logic [31:0] out_reg;

  assign cnt_hit = (data_addr == 32'hFFFF_FF00);
  assign out_hit = (data_addr == 32'hFFFF_FF04);

  always_ff @(posedge clk) begin
    if (reset) begin
      cycle_cnt <= '0;
      out_reg   <= '0;
    end else begin
      cycle_cnt <= cycle_cnt + 32'd1;
      if (accept && data_write && !data_read && out_hit)
        out_reg <= data_wdata;
    end
  end

  assign mmio_rdata = cnt_hit ? cycle_cnt : (out_hit ? out_reg : 32'd0);
  assign out_port   = out_reg;
`else
  assign cnt_hit    = 1'b0;
  assign out_hit    = 1'b0;
  assign mmio_rdata = 32'd0;
  assign out_port   = 32'd0;
`endif

  always_comb begin
    rd_val = 32'd0;
    if (!both) begin
      if (ram_hit)
        rd_val = mem[word_idx];
      else
        rd_val = mmio_rdata;
    end
  end

  // RAM has no reset so it maps onto block memory.
  always_ff @(posedge clk) begin
    if (ram_write)
      mem[word_idx] <= data_wdata;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      data_rdata <= '0;
      data_err   <= 1'b0;
    end else if (accept) begin
      if (data_read)
        data_rdata <= rd_val;
      if (req_err)
        data_err <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= S_IDLE;
      wait_cnt <= '0;
    end else begin
      state    <= state_nxt;
      wait_cnt <= wait_cnt_nxt;
    end
  end

  always_comb begin
    state_nxt    = state;
    wait_cnt_nxt = wait_cnt;
    data_ready   = 1'b0;
    case (state)
      S_IDLE: begin
        if (data_read || data_write) begin
          if (WAIT_CYCLES == 0) begin
            state_nxt = S_RESP;
          end else begin
            state_nxt    = S_WAIT;
            wait_cnt_nxt = WAIT_LOAD;
          end
        end
      end
      S_WAIT: begin
        if (wait_cnt == 4'd0)
          state_nxt = S_RESP;
        else
          wait_cnt_nxt = wait_cnt - 4'd1;
      end
      S_RESP: begin
        data_ready = 1'b1;
        state_nxt  = S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

endmodule

`default_nettype wire
